// File: rtl/if_fetch_queue_if.sv
// Bundle between PC-source logic, instruction memory and ID.
// The queue drives the master side; the environment drives the slave side.
interface if_fetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              fetch_en;
  logic              redirect;
  logic [1:0]        sel;
  logic [ADDR_W-1:0] ta;
  logic [ADDR_W-1:0] alu_out;
  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_data;
  logic              id_valid;
  logic              id_ready;
  logic [INST_W-1:0] id_instr;
  logic [ADDR_W-1:0] id_pc;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;

  modport master (
    input  fetch_en, redirect, sel, ta, alu_out,
    input  imem_data, id_ready,
    output imem_addr, id_valid, id_instr, id_pc,
    output count, full, empty
  );

  modport slave (
    output fetch_en, redirect, sel, ta, alu_out,
    output imem_data, id_ready,
    input  imem_addr, id_valid, id_instr, id_pc,
    input  count, full, empty
  );
endinterface

// File: rtl/if_fetch_queue.sv
// IF stage: PC/nPC, combinational imem address, and a DEPTH-entry
// {pc, instr} queue feeding ID over valid/ready.
module if_fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] INC      = ADDR_W'(4)
) (
  input logic             clk,
  input logic             R,
  if_fetch_queue_if.master q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] npc_q, npc_d;
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] pcs_q [DEPTH];
  logic [INST_W-1:0] ins_q [DEPTH];
  logic [ADDR_W-1:0] tgt;
  logic              full, empty, push, pop;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign pop   = ~empty & q.id_ready;
  assign push  = q.fetch_en & ~q.redirect & (~full | pop);

  always_comb begin
    unique case (q.sel)
      2'b00:   tgt = npc_q;
      2'b01:   tgt = q.ta;
      2'b10:   tgt = q.alu_out;
      default: tgt = '0;
    endcase
  end

  always_comb begin
    pc_d   = pc_q;
    npc_d  = npc_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (q.redirect) begin
      // flush wins over any pop/push this cycle
      pc_d   = tgt;
      npc_d  = tgt + INC;
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) begin
        pc_d   = npc_q;
        npc_d  = npc_q + INC;
        tail_d = tail_q + 1'b1;
      end
      if (pop) head_d = head_q + 1'b1;
      if (push & ~pop) cnt_d = cnt_q + 1'b1;
      if (pop & ~push) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      pc_q   <= RESET_PC;
      npc_q  <= RESET_PC + INC;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      npc_q  <= npc_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pcs_q[tail_q] <= pc_q;
      ins_q[tail_q] <= q.imem_data;
    end
  end

  assign q.imem_addr = pc_q;
  assign q.id_valid  = ~empty;
  assign q.id_pc     = empty ? '0 : pcs_q[head_q];
  assign q.id_instr  = empty ? '0 : ins_q[head_q];
  assign q.count     = cnt_q;
  assign q.full      = full;
  assign q.empty     = empty;
endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: vector table plus scoreboard of
// fetched {pc, instr} pairs, then wrap and async-reset sequences.
module tb_if_fetch_queue;
  logic clk = 1'b0;
  logic R   = 1'b0;
  always #5 clk = ~clk;

  if_fetch_queue_if #(.ADDR_W(32), .INST_W(32), .DEPTH(4)) bus ();

  if_fetch_queue #(
    .ADDR_W(32), .INST_W(32), .DEPTH(4),
    .RESET_PC(32'h0), .INC(32'h4)
  ) dut (
    .clk(clk),
    .R  (R),
    .q  (bus)
  );

  always_comb bus.imem_data = 32'hA000_0000 | bus.imem_addr;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  typedef struct {
    logic        rst;
    logic        fe;
    logic        rd;
    logic [1:0]  sel;
    logic [31:0] ta;
    logic [31:0] alu;
    logic        rdy;
    int          cnt;
    logic [31:0] addr;
  } vec_t;

  ent_t        sb [$];
  vec_t        tbl [$];
  logic [31:0] pc_m, npc_m;
  int          npass = 0;
  int          ntot  = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic rst, input logic fe,
      input logic rd, input logic [1:0] sel, input logic [31:0] ta,
      input logic [31:0] alu, input logic rdy, input int cnt,
      input logic [31:0] addr);
    vec_t v;
    v.rst = rst; v.fe = fe; v.rd = rd; v.sel = sel; v.ta = ta;
    v.alu = alu; v.rdy = rdy; v.cnt = cnt; v.addr = addr;
    return v;
  endfunction

  task automatic post_chk();
    chk("count", 64'(bus.count), 64'(sb.size()));
    chk("empty", 64'(bus.empty), 64'(sb.size() == 0));
    chk("full", 64'(bus.full), 64'(sb.size() == 4));
    chk("id_valid", 64'(bus.id_valid), 64'(sb.size() != 0));
    chk("id_pc", 64'(bus.id_pc), sb.size() ? 64'(sb[0].pc) : 64'd0);
    chk("id_instr", 64'(bus.id_instr),
        sb.size() ? 64'(sb[0].ins) : 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    R = 1'b1;
    #2;
    sb.delete();
    pc_m  = 32'h0;
    npc_m = 32'h4;
    chk("rst_addr", 64'(bus.imem_addr), 64'h0);
    post_chk();
    @(negedge clk);
    R = 1'b0;
  endtask

  task automatic cycle(input logic fe, input logic rd,
      input logic [1:0] sel, input logic [31:0] ta,
      input logic [31:0] alu, input logic rdy);
    logic        pop, push;
    logic [31:0] t;
    bus.fetch_en = fe;
    bus.redirect = rd;
    bus.sel      = sel;
    bus.ta       = ta;
    bus.alu_out  = alu;
    bus.id_ready = rdy;
    #1;
    chk("imem_addr", 64'(bus.imem_addr), 64'(pc_m));
    if (rd) begin
      case (sel)
        2'b00:   t = npc_m;
        2'b01:   t = ta;
        2'b10:   t = alu;
        default: t = 32'h0;
      endcase
      sb.delete();
      pc_m  = t;
      npc_m = t + 32'h4;
    end else begin
      pop  = (sb.size() != 0) && rdy;
      push = fe && ((sb.size() < 4) || pop);
      if (pop) void'(sb.pop_front());
      if (push) begin
        sb.push_back('{pc: pc_m, ins: 32'hA000_0000 | pc_m});
        pc_m  = npc_m;
        npc_m = npc_m + 32'h4;
      end
    end
    @(posedge clk);
    #1;
    post_chk();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout");
    $fatal(1);
  end

  initial begin
    bus.fetch_en = 1'b0;
    bus.redirect = 1'b0;
    bus.sel      = 2'b00;
    bus.ta       = '0;
    bus.alu_out  = '0;
    bus.id_ready = 1'b0;
    pc_m  = 32'h0;
    npc_m = 32'h4;

    // streaming, then fill / full-swap, then redirects
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 32'h4));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 32'h8));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 32'hC));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 32'h10));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 32'h4));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 2, 32'h8));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 3, 32'hC));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 4, 32'h10));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 4, 32'h10));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 4, 32'h14));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 3, 32'h14));
    tbl.push_back(mk(0, 0, 1, 1, 32'h200, 0, 0, 0, 32'h200));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 32'h204));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 32'h208));
    tbl.push_back(mk(0, 1, 1, 2, 0, 32'h3C, 1, 0, 32'h3C));
    tbl.push_back(mk(0, 0, 1, 3, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 32'h4));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 32'h8));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      cycle(tbl[i].fe, tbl[i].rd, tbl[i].sel, tbl[i].ta,
            tbl[i].alu, tbl[i].rdy);
      chk($sformatf("vec%0d_cnt", i), 64'(bus.count), 64'(tbl[i].cnt));
      chk($sformatf("vec%0d_addr", i), 64'(bus.imem_addr),
          64'(tbl[i].addr));
    end

    // address wrap at the top of the space
    cycle(0, 1, 2'b01, 32'hFFFF_FFFC, 0, 0);
    chk("wrap_pc", 64'(bus.imem_addr), 64'hFFFF_FFFC);
    cycle(1, 0, 2'b00, 0, 0, 0);
    chk("wrap_to0", 64'(bus.imem_addr), 64'h0);
    cycle(1, 0, 2'b00, 0, 0, 0);
    chk("wrap_cnt", 64'(bus.count), 64'd2);
    chk("wrap_head", 64'(bus.id_pc), 64'hFFFF_FFFC);

    // async reset between edges clears everything at once
    #2;
    R = 1'b1;
    #1;
    chk("arst_cnt", 64'(bus.count), 64'd0);
    chk("arst_valid", 64'(bus.id_valid), 64'd0);
    chk("arst_pc", 64'(bus.imem_addr), 64'd0);
    chk("arst_empty", 64'(bus.empty), 64'd1);
    sb.delete();
    pc_m  = 32'h0;
    npc_m = 32'h4;
    @(negedge clk);
    R = 1'b0;
    cycle(1, 0, 2'b00, 0, 0, 1);
    chk("post_rst_addr", 64'(bus.imem_addr), 64'h4);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Parametrised successor to the single-register IF stage. It holds PC/nPC, drives the combinational instruction memory address, and buffers fetched {pc, instruction} pairs in a DEPTH-entry queue. The queue feeds the ID stage through a valid/ready handshake, so a stall in ID no longer freezes fetch. It sits between the PC-source selection (nPC / TA / ALU) and the ID stage, and replaces the direct IF/ID register.

Parameters:
ADDR_W, 32, width of PC, nPC, ta, alu_out, imem_addr, id_pc
INST_W, 32, instruction width
DEPTH, 4, queue entries; power of two, >= 2
RESET_PC, 0, PC value after reset; nPC resets to RESET_PC+INC
INC, 4, sequential increment in bytes

Ports:
clk  in  1  clock
R  in  1  reset, asynchronous, active-high
fetch_en  in  1  load enable for fetch; 0 = hold PC/nPC and push nothing
redirect  in  1  PC-source change this cycle
sel  in  2  PC source when redirect=1: 00 nPC, 01 ta, 10 alu_out, 11 zero
ta  in  ADDR_W  branch/call target address
alu_out  in  ADDR_W  jmpl/register target
imem_addr  out  ADDR_W  current PC, driven to instruction memory
imem_data  in  INST_W  instruction at imem_addr, same cycle (combinational memory)
id_valid  out  1  head entry valid
id_ready  in  1  ID accepts head this cycle
id_instr  out  INST_W  head instruction
id_pc  out  ADDR_W  head PC
count  out  clog2(DEPTH)+1  occupied entries
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Reset (async, R=1): PC=RESET_PC, nPC=RESET_PC+INC, pointers=0, count=0, id_valid=0, id_instr=0, id_pc=0, full=0, empty=1. Reset takes effect immediately and holds while R=1, including mid-operation; there is no partial drain.
- imem_addr = PC (combinational).
- pop = id_valid & id_ready.
- push = fetch_en & ~redirect & (~full | pop). Push writes {PC, imem_data} at the tail. PC<=nPC and nPC<=nPC+INC happen on the same edge.
- No push: PC and nPC hold.
- Redirect (highest priority below reset), on the edge:
  - target = sel-selected value.
  - PC<=target, nPC<=target+INC.
  - Queue cleared: count=0, pointers=0.
  - No push; any pop that cycle is discarded.
  - id_valid=0 from the next cycle.
- Redirect with fetch_en=0 still updates PC/nPC and clears the queue.
- Simultaneous push and pop when full: allowed; count unchanged; order preserved.
- Simultaneous push and pop when count=1: head advances to the new entry; count stays 1.
- Pop when empty: impossible, since id_valid=0.
- id_valid = ~empty. id_instr/id_pc come from the registered head entry and read as 0 when empty.
- No bypass: fetch at edge n is visible at the ID outputs after edge n, i.e. latency 1 cycle.
- All address arithmetic is modulo 2^ADDR_W; nPC+INC wraps silently.
- Pointers are clog2(DEPTH) bits and wrap naturally. count is derived as a registered counter: +1 on push-only, -1 on pop-only.

Test Plan:
- Reset then fetch_en=1, id_ready=1, imem returns 0xA0000000|addr: id_pc sequence 0,4,8,C on consecutive cycles after 1-cycle latency. id_instr matches.
- id_ready=0, fetch_en=1 from reset: after 4 edges count=4, full=1, PC=0x10 held. Raise id_ready for 1 cycle: pop pc 0 and push pc 0x10 on the same edge; count stays 4.
- Queue holding 3 entries, redirect=1, sel=01, ta=0x200: next cycle count=0, id_valid=0, imem_addr=0x200. The following cycle id_pc=0x200, and nPC=0x208 internally (next fetch 0x204).
- redirect with sel=10, alu_out=0x3C, and pop asserted on the same edge: pop discarded, queue empty, PC=0x3C. sel=11 gives PC=0, nPC=4.
- ADDR_W=32, PC at 0xFFFFFFFC: fetch wraps to 0x00000000. Assert R asynchronously between edges with count=2: count=0, id_valid=0, PC=RESET_PC immediately, without waiting for a clock edge.
